// File: rtl/cypher.sv
// rtl/cypher.sv - LFSR-pad stream cipher: one load yields msg XOR pad after N clock edges.
// The same operation encrypts and decrypts.
module cypher #(
  parameter int MSG_SIZE = 32,
  parameter int KEY_SIZE = 4,
  parameter logic [KEY_SIZE-1:0] TAPS = 4'b1100
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [MSG_SIZE-1:0] msg,
  input  logic [KEY_SIZE-1:0] key,
  output logic [MSG_SIZE-1:0] out,
  output logic                valid,
  output logic                busy
);

  localparam int N     = MSG_SIZE / KEY_SIZE;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  typedef enum logic {IDLE, GEN} state_t;

  state_t              state;
  logic [MSG_SIZE-1:0] msg_reg;
  logic [MSG_SIZE-1:0] pad;
  logic [MSG_SIZE-1:0] pad_next;
  logic [KEY_SIZE-1:0] lfsr;
  logic [KEY_SIZE-1:0] lfsr_next;
  logic [CNT_W-1:0]    cnt;
  logic                fb;

  always_comb begin
    fb        = ^(lfsr & TAPS);
    lfsr_next = {lfsr[KEY_SIZE-2:0], fb};
  end

  // Pad with the current LFSR value dropped into chunk cnt; the final edge uses this
  // directly so the last chunk reaches out on the same edge it is generated.
  always_comb begin
    pad_next = pad;
    for (int i = 0; i < N; i++) begin
      if (cnt == CNT_W'(i)) begin
        pad_next[i*KEY_SIZE +: KEY_SIZE] = lfsr;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      msg_reg <= '0;
      pad     <= '0;
      lfsr    <= '0;
      cnt     <= '0;
      out     <= '0;
      valid   <= 1'b0;
      busy    <= 1'b0;
    end else if (load) begin
      // A load in any state (re)starts generation; out keeps its last result.
      state   <= GEN;
      msg_reg <= msg;
      pad     <= '0;
      lfsr    <= (key == '0) ? KEY_SIZE'(1) : key;
      cnt     <= '0;
      valid   <= 1'b0;
      busy    <= 1'b1;
    end else if (state == GEN) begin
      pad  <= pad_next;
      lfsr <= lfsr_next;
      cnt  <= cnt + 1'b1;
      if (cnt == LAST) begin
        out   <= msg_reg ^ pad_next;
        valid <= 1'b1;
        busy  <= 1'b0;
        state <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_cypher.sv
// tb/tb_cypher.sv - self-checking bench for cypher against an arithmetic pad model.
module tb_cypher;

  logic        clk;
  logic        rst;
  logic        load;
  logic [31:0] msg;
  logic [3:0]  key;
  logic [31:0] out;
  logic        valid;
  logic        busy;

  int checks;
  int failures;

  cypher dut (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .msg   (msg),
    .key   (key),
    .out   (out),
    .valid (valid),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Pad built from the polynomial x^4+x^3+1 with integer arithmetic, chunk 0 in the LSBs.
  function automatic logic [31:0] model(input logic [31:0] m, input logic [3:0] k);
    int unsigned s;
    int unsigned b;
    logic [31:0] p;
    s = (k == 4'd0) ? 1 : int'(k);
    p = '0;
    for (int i = 0; i < 8; i++) begin
      p = p | (32'(s) << (4 * i));
      b = ((s / 8) % 2) ^ ((s / 4) % 2);
      s = ((s * 2) % 16) + b;
    end
    return m ^ p;
  endfunction

  // Pulses load for one edge, then scrambles msg/key; leaves the bench just after a negedge.
  task automatic start(input logic [31:0] m, input logic [3:0] k);
    @(negedge clk);
    msg  = m;
    key  = k;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    msg  = $urandom;
    key  = 4'($urandom);
  endtask

  // Walks the 8 edges after a load edge, checking busy/valid timing and the final result.
  task automatic finish_and_check(input string tag, input logic [31:0] exp);
    check({tag, "_busy0"}, 32'(busy), 32'd1);
    for (int e = 1; e <= 8; e++) begin
      @(negedge clk);
      msg = $urandom;
      key = 4'($urandom);
      if (e < 8) begin
        check({tag, "_valid_early"}, 32'(valid), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd1);
      end else begin
        check({tag, "_valid"}, 32'(valid), 32'd1);
        check({tag, "_busy_done"}, 32'(busy), 32'd0);
        check({tag, "_out"}, out, exp);
      end
    end
  endtask

  initial begin
    logic [31:0] m;
    logic [3:0]  k;
    logic [31:0] held;
    checks   = 0;
    failures = 0;
    rst  = 1'b1;
    load = 1'b1;
    msg  = 32'hDEADBEEF;
    key  = 4'h5;
    #3;
    check("reset_out", out, 32'd0);
    check("reset_valid", 32'(valid), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    @(negedge clk);
    load = 1'b0;
    rst  = 1'b0;

    start(32'hABCDEF01, 4'hA);
    finish_and_check("nominal", 32'h2722945B);
    check("nominal_model", model(32'hABCDEF01, 4'hA), 32'h2722945B);

    start(32'h2722945B, 4'hA);
    finish_and_check("roundtrip", 32'hABCDEF01);

    start(32'h0, 4'h0);
    finish_and_check("zerokey", 32'hAD639421);

    // Restart: second load 3 edges after the first; out from the previous result must hold.
    held = out;
    start(32'hFFFFFFFF, 4'h3);
    for (int e = 0; e < 2; e++) begin
      @(negedge clk);
      check("restart_valid_first", 32'(valid), 32'd0);
      check("restart_out_hold", out, held);
    end
    start(32'hABCDEF01, 4'hA);
    finish_and_check("restart", 32'h2722945B);

    // Hold after completion.
    held = out;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      msg = $urandom;
      key = 4'($urandom);
      check("hold_out", out, held);
      check("hold_valid", 32'(valid), 32'd1);
    end

    // Sustained load never completes; the last captured word is what finishes.
    @(negedge clk);
    load = 1'b1;
    for (int c = 0; c < 12; c++) begin
      m   = $urandom;
      k   = 4'($urandom);
      msg = m;
      key = k;
      @(negedge clk);
      check("sustain_valid", 32'(valid), 32'd0);
      check("sustain_busy", 32'(busy), 32'd1);
    end
    load = 1'b0;
    finish_and_check("sustain_end", model(m, k));

    for (int t = 0; t < 30; t++) begin
      m = $urandom;
      k = 4'($urandom_range(0, 15));
      if (t == 0) k = 4'h0;
      if (t == 1) k = 4'hF;
      start(m, k);
      finish_and_check("random", model(m, k));
    end

    // Asynchronous reset in the middle of generation.
    start(32'h12345678, 4'h9);
    @(negedge clk);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("midgen_rst_out", out, 32'd0);
    check("midgen_rst_valid", 32'(valid), 32'd0);
    check("midgen_rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    start(32'h12345678, 4'h9);
    finish_and_check("after_rst", model(32'h12345678, 4'h9));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
